// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester's request/response channel into the data
// memory arbiter. The requester side uses the master modport, the arbiter
// uses the slave modport.
interface dmem_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_lock;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lock, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lock, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter in front of a single-port
// data memory (combinational read, synchronous write). One transaction is in
// flight at a time: IDLE accepts a request and drives the memory port,
// RESP holds the registered response until the owner consumes it.
// Optional feature: define DMEM_ARB_LOCK_EN to let a requester keep the
// grant across transactions (atomic read-modify-write) via req_lock.
module dmem_arbiter #(
  parameter int DEPTH = 1024
) (
  input  logic         clk,
  input  logic         reset,
  dmem_arbiter_if.slave r0,
  dmem_arbiter_if.slave r1,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_data,
  output logic         mem_write,
  output logic         mem_read,
  input  logic [31:0]  mem_rdata
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        own_q, own_d;
  logic        last_q, last_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        elig0, elig1;
  logic        gnt0, gnt1;
  logic        hs;
  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;
  logic        rsp_done;

`ifdef DMEM_ARB_LOCK_EN
  logic        locked_q, locked_d;
  logic        lock_own_q, lock_own_d;
  logic        sel_lock;
`else
  logic        unused_lock;
  assign unused_lock = r0.req_lock ^ r1.req_lock;
`endif

  // Grant selection: eligible requesters, round-robin tie break, request mux
  always_comb begin
    elig0 = r0.req_valid & (state_q == IDLE) & ~reset;
    elig1 = r1.req_valid & (state_q == IDLE) & ~reset;
`ifdef DMEM_ARB_LOCK_EN
    // While locked only the lock holder may win, whatever the pointer says
    if (locked_q) begin
      elig0 = elig0 & ~lock_own_q;
      elig1 = elig1 &  lock_own_q;
    end
`endif
    // On a tie the requester that was not served last wins
    gnt1      = elig1 & (~elig0 | ~last_q);
    gnt0      = elig0 & ~gnt1;
    hs        = gnt0 | gnt1;
    sel       = gnt1;
    sel_we    = sel ? r1.req_we    : r0.req_we;
    sel_addr  = sel ? r1.req_addr  : r0.req_addr;
    sel_wdata = sel ? r1.req_wdata : r0.req_wdata;
    in_range  = (sel_addr < DEPTH_W);
`ifdef DMEM_ARB_LOCK_EN
    sel_lock  = sel ? r1.req_lock  : r0.req_lock;
`endif
  end

  // Output drive: same-cycle ready and memory access, registered response
  always_comb begin
    r0.req_ready = gnt0;
    r1.req_ready = gnt1;
    mem_addr     = hs ? sel_addr  : '0;
    mem_data     = hs ? sel_wdata : '0;
    // Out-of-range writes never reach the memory
    mem_write    = hs & sel_we & in_range;
    mem_read     = hs & ~sel_we;
    r0.rsp_valid = (state_q == RESP) & ~own_q & ~reset;
    r1.rsp_valid = (state_q == RESP) &  own_q & ~reset;
    r0.rsp_rdata = r0.rsp_valid ? rdata_q : '0;
    r1.rsp_rdata = r1.rsp_valid ? rdata_q : '0;
    r0.rsp_err   = r0.rsp_valid & err_q;
    r1.rsp_err   = r1.rsp_valid & err_q;
  end

  // Next-state logic: capture the transaction result on handshake, release on response
  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    last_d   = last_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    rsp_done = own_q ? r1.rsp_ready : r0.rsp_ready;
`ifdef DMEM_ARB_LOCK_EN
    locked_d   = locked_q;
    lock_own_d = lock_own_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = RESP;
          own_d   = sel;
          last_d  = sel;
          // Writes and errors return zero data
          rdata_d = (~sel_we & in_range) ? mem_rdata : '0;
          err_d   = ~in_range;
`ifdef DMEM_ARB_LOCK_EN
          if (sel_lock) begin
            locked_d   = 1'b1;
            lock_own_d = sel;
          end else if (locked_q && (lock_own_q == sel)) begin
            locked_d   = 1'b0;
          end
`endif
        end
      end
      RESP: begin
        if (rsp_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and response registers; reset drops any pending response
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      own_q   <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  // Bus lock registers
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q   <= 1'b0;
      lock_own_q <= 1'b0;
    end else begin
      locked_q   <= locked_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: two queued requester drivers, a behavioural memory, and a
// scoreboard monitor holding a transaction-level model of the arbiter
// (outstanding flag, last winner, lock holder, memory contents).
module tb_dmem_arbiter;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if r0_if ();
  dmem_arbiter_if r1_if ();

  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic        mem_write, mem_read;

  dmem_arbiter #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .r0        (r0_if),
    .r1        (r1_if),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_rdata (mem_rdata)
  );

  logic        req_valid [2];
  logic        req_we    [2];
  logic        req_lock  [2];
  logic        rsp_ready [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_err   [2];
  logic [31:0] rsp_rdata [2];

  assign r0_if.req_valid = req_valid[0];
  assign r0_if.req_we    = req_we[0];
  assign r0_if.req_lock  = req_lock[0];
  assign r0_if.req_addr  = req_addr[0];
  assign r0_if.req_wdata = req_wdata[0];
  assign r0_if.rsp_ready = rsp_ready[0];
  assign r1_if.req_valid = req_valid[1];
  assign r1_if.req_we    = req_we[1];
  assign r1_if.req_lock  = req_lock[1];
  assign r1_if.req_addr  = req_addr[1];
  assign r1_if.req_wdata = req_wdata[1];
  assign r1_if.rsp_ready = rsp_ready[1];
  assign req_ready[0] = r0_if.req_ready;
  assign req_ready[1] = r1_if.req_ready;
  assign rsp_valid[0] = r0_if.rsp_valid;
  assign rsp_valid[1] = r1_if.rsp_valid;
  assign rsp_err[0]   = r0_if.rsp_err;
  assign rsp_err[1]   = r1_if.rsp_err;
  assign rsp_rdata[0] = r0_if.rsp_rdata;
  assign rsp_rdata[1] = r1_if.rsp_rdata;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Power-on memory contents, known to both the memory and the model
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural single-port memory: combinational read, synchronous write
  logic [31:0] mem [DEPTH];
  bit          written [DEPTH];
  assign mem_rdata = (mem_addr < DEPTH) ?
                     (written[mem_addr[9:0]] ? mem[mem_addr[9:0]] : init_val(mem_addr)) :
                     32'hBAD0BAD0;
  always @(posedge clk) begin
    if (mem_write && mem_addr < DEPTH) begin
      mem[mem_addr[9:0]]     <= mem_data;
      written[mem_addr[9:0]] <= 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        lock;
    int          gap;
    bit          abandon;
  } stim_t;

  stim_t sq0[$];
  stim_t sq1[$];
  bit    drv_idle [2];
  bit    hold     [2];

  task automatic push(input int n, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic lock, input int gap,
                      input bit ab);
    stim_t s;
    s.we = we; s.addr = addr; s.wdata = wdata; s.lock = lock; s.gap = gap; s.abandon = ab;
    if (n == 0) sq0.push_back(s);
    else        sq1.push_back(s);
  endtask

  task automatic driver(input int n);
    stim_t s;
    int    waited;
    req_valid[n] = 1'b0; req_we[n] = 1'b0; req_lock[n] = 1'b0;
    req_addr[n] = '0; req_wdata[n] = '0;
    drv_idle[n] = 1'b1;
    @(posedge clk); #1;
    forever begin
      if ((n == 0 ? sq0.size() : sq1.size()) == 0) begin
        drv_idle[n]  = 1'b1;
        req_valid[n] = 1'b0;
        @(posedge clk); #1;
        continue;
      end
      drv_idle[n] = 1'b0;
      if (n == 0) s = sq0.pop_front();
      else        s = sq1.pop_front();
      if (s.gap > 0) req_valid[n] = 1'b0;
      repeat (s.gap) begin @(posedge clk); #1; end
      req_we[n] = s.we; req_addr[n] = s.addr; req_wdata[n] = s.wdata; req_lock[n] = s.lock;
      req_valid[n] = 1'b1;
      waited = 0;
      forever begin
        @(negedge clk);
        if (req_ready[n]) break;
        waited++;
        if (s.abandon && waited >= 2) break;
        if (waited > 3000) begin
          tests++; fails++;
          $display("FAIL r%0d_req_timeout: req_ready 0 for %0d cycles, expected a grant", n, waited);
          break;
        end
      end
      @(posedge clk); #1;
      req_valid[n] = 1'b0;
    end
  endtask

  initial driver(0);
  initial driver(1);

  // Response-side consumer: random back-pressure unless held
  initial begin
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b0;
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++)
        rsp_ready[k] = hold[k] ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        eq0[$];
  exp_t        eq1[$];
  logic [31:0] ref_mem [int unsigned];
  bit          m_busy = 1'b0;
  bit          m_own = 1'b0;
  bit          m_last = 1'b1;
  bit          m_locked = 1'b0;
  bit          m_lock_own = 1'b0;
  int          grant_log[$];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  always @(negedge clk) begin
    bit   e0, e1, g0, g1, inr;
    exp_t x;
    int   n;
    if (reset) begin
      chk("mem_write_in_reset", {31'b0, mem_write}, 32'd0);
      m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_locked = 1'b0;
      eq0.delete(); eq1.delete();
    end else begin
      // Who should be granted this cycle
      e0 = req_valid[0] && !m_busy && (!m_locked || m_lock_own == 1'b0);
      e1 = req_valid[1] && !m_busy && (!m_locked || m_lock_own == 1'b1);
      if (e0 && e1) begin
        g0 = (m_last == 1'b1);
        g1 = (m_last == 1'b0);
      end else begin
        g0 = e0;
        g1 = e1;
      end
      chk("r0_req_ready", {31'b0, req_ready[0]}, {31'b0, g0});
      chk("r1_req_ready", {31'b0, req_ready[1]}, {31'b0, g1});
      chk("r0_rsp_valid", {31'b0, rsp_valid[0]}, {31'b0, m_busy && m_own == 1'b0});
      chk("r1_rsp_valid", {31'b0, rsp_valid[1]}, {31'b0, m_busy && m_own == 1'b1});

      // Response scoreboard
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid[k]) begin
          if ((k == 0 ? eq0.size() : eq1.size()) == 0) begin
            tests++; fails++;
            $display("FAIL r%0d_rsp_unexpected: rsp_valid 1, expected 0 (nothing outstanding)", k);
          end else begin
            x = (k == 0) ? eq0[0] : eq1[0];
            chk($sformatf("r%0d_rsp_rdata", k), rsp_rdata[k], x.rdata);
            chk($sformatf("r%0d_rsp_err", k), {31'b0, rsp_err[k]}, {31'b0, x.err});
            if (rsp_ready[k]) begin
              if (k == 0) void'(eq0.pop_front());
              else        void'(eq1.pop_front());
              m_busy = 1'b0;
            end
          end
        end
      end

      // Request side: follow the observed handshake into the model
      if ((req_valid[0] && req_ready[0]) || (req_valid[1] && req_ready[1])) begin
        n   = (req_valid[1] && req_ready[1]) ? 1 : 0;
        inr = (req_addr[n] < DEPTH);
        chk("mem_addr", mem_addr, req_addr[n]);
        chk("mem_read", {31'b0, mem_read}, {31'b0, !req_we[n]});
        chk("mem_write", {31'b0, mem_write}, {31'b0, req_we[n] && inr});
        if (req_we[n]) begin
          chk("mem_data", mem_data, req_wdata[n]);
          if (inr) ref_mem[req_addr[n]] = req_wdata[n];
          x.rdata = 32'd0;
        end else begin
          x.rdata = inr ? ref_read(req_addr[n]) : 32'd0;
        end
        x.err = !inr;
        if (n == 0) eq0.push_back(x);
        else        eq1.push_back(x);
        m_busy = 1'b1;
        m_own  = (n == 1);
        m_last = (n == 1);
        grant_log.push_back(n);
`ifdef DMEM_ARB_LOCK_EN
        if (req_lock[n]) begin
          m_locked   = 1'b1;
          m_lock_own = (n == 1);
        end else if (m_locked && m_lock_own == (n == 1)) begin
          m_locked = 1'b0;
        end
`endif
      end else begin
        chk("mem_write_idle", {31'b0, mem_write}, 32'd0);
        chk("mem_read_idle", {31'b0, mem_read}, 32'd0);
      end
    end
  end

  // ---------------- sequence ----------------
  task automatic drain(input string name);
    int c;
    c = 0;
    while ((sq0.size() != 0 || sq1.size() != 0 || !drv_idle[0] || !drv_idle[1] || m_busy)
           && c < 5000) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c >= 5000) begin
      fails++;
      $display("FAIL drain_%s: still busy after %0d cycles, expected idle", name, c);
    end
  endtask

  task automatic wait_rsp(input int n, input string name);
    int c;
    c = 0;
    while (!rsp_valid[n] && c < 200) begin
      @(negedge clk);
      c++;
    end
    tests++;
    if (c >= 200) begin
      fails++;
      $display("FAIL %s: rsp_valid 0 after %0d cycles, expected 1", name, c);
    end
  endtask

  initial begin
    logic [31:0] cap;
    logic [31:0] a;
    int          r;
    int          c;
    reset = 1'b1;
    hold[0] = 1'b0; hold[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_r0_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    chk("reset_r1_rsp_valid", {31'b0, rsp_valid[1]}, 32'd0);
    chk("reset_mem_write", {31'b0, mem_write}, 32'd0);

    // Write then read back through requester 0
    push(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    push(0, 1'b0, 32'd5, 32'd0,        1'b0, 0, 1'b0);
    drain("write_read");

    // Continuous contention: grants must alternate, r1 first since r0 won last
    grant_log.delete();
    for (int i = 0; i < 6; i++) begin
      push(0, 1'b0, 32'(i), 32'd0, 1'b0, 0, 1'b0);
      push(1, 1'b1, 32'(i + 8), $urandom, 1'b0, 0, 1'b0);
    end
    drain("alternate");
    chk("alt_count", 32'(grant_log.size()), 32'd12);
    if (grant_log.size() > 0) chk("alt_first", 32'(grant_log[0]), 32'd1);
    for (int i = 1; i < grant_log.size(); i++)
      chk($sformatf("alt_%0d", i), 32'(grant_log[i]), 32'(1 - grant_log[i-1]));

    // Range boundary: just past the end and the last valid word
    push(1, 1'b1, 32'd1024, 32'h12345678, 1'b0, 0, 1'b0);
    push(1, 1'b0, 32'd1024, 32'd0,        1'b0, 0, 1'b0);
    push(0, 1'b1, 32'd1023, 32'hCAFEF00D, 1'b0, 0, 1'b0);
    push(0, 1'b0, 32'd1023, 32'd0,        1'b0, 0, 1'b0);
    drain("range");

    // Back-pressure: held response stays stable, other requester blocked
    hold[0] = 1'b1;
    push(0, 1'b0, 32'd5, 32'd0, 1'b0, 0, 1'b0);
    push(1, 1'b1, 32'd9, 32'h0BADC0DE, 1'b0, 0, 1'b0);
    wait_rsp(0, "hold_rsp");
    cap = rsp_rdata[0];
    chk("hold_rdata_value", cap, 32'hDEADBEEF);
    repeat (3) begin
      @(negedge clk);
      chk("hold_rdata_stable", rsp_rdata[0], cap);
      chk("hold_rsp_valid", {31'b0, rsp_valid[0]}, 32'd1);
      chk("hold_r1_blocked", {31'b0, req_ready[1]}, 32'd0);
    end
    hold[0] = 1'b0;
    drain("hold");

    // Reset while a response is pending
    hold[0] = 1'b1;
    push(0, 1'b0, 32'd9, 32'd0, 1'b0, 0, 1'b0);
    wait_rsp(0, "pre_reset_rsp");
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    hold[0] = 1'b0;
    @(negedge clk);
    chk("post_reset_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    push(0, 1'b0, 32'd1, 32'd0, 1'b0, 0, 1'b0);
    push(1, 1'b0, 32'd2, 32'd0, 1'b0, 0, 1'b0);
    c = 0;
    while (!req_ready[0] && !req_ready[1] && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("post_reset_first_r0", {31'b0, req_ready[0]}, 32'd1);
    drain("post_reset");

    // Randomised traffic with mixed gaps, out-of-range addresses and abandons
    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'(DEPTH) + 32'($urandom_range(0, 100));
        else if (r == 1) a = $urandom;
        else if (r == 2) a = 32'(DEPTH - 1);
        else             a = 32'($urandom_range(0, 15));
        push(k, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0));
      end
    end
    drain("random");

`ifdef DMEM_ARB_LOCK_EN
    // Locked read-modify-write by r1 keeps r0 out until the unlocking write
    grant_log.delete();
    push(1, 1'b0, 32'd3, 32'd0,        1'b1, 0, 1'b0);
    push(1, 1'b1, 32'd3, 32'h55AA55AA, 1'b0, 4, 1'b0);
    push(0, 1'b0, 32'd3, 32'd0,        1'b0, 1, 1'b0);
    drain("lock");
    chk("lock_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      chk("lock_g0", 32'(grant_log[0]), 32'd1);
      chk("lock_g1", 32'(grant_log[1]), 32'd1);
      chk("lock_g2", 32'(grant_log[2]), 32'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
